// File: rtl/fp_writeback_pkg.sv
// Shared types for fp_writeback: FSM states, status codes and the stage-entry layout.
// Field widths match the default configuration (32-bit results, 32 registers).
package fp_writeback_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_RD_W   = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT_EXC = 2'd1,
    ST_HALT_EOF = 2'd2
  } state_e;

  localparam logic [1:0] STATUS_OK  = 2'b00;
  localparam logic [1:0] STATUS_EXC = 2'b10;
  localparam logic [1:0] STATUS_EOF = 2'b11;

  typedef struct packed {
    logic [FP_DATA_W-1:0] result;
    logic                 exception;
    logic [FP_RD_W-1:0]   rd;
    logic                 eof;
  } stage_t;

  // Exception outranks end-of-program when both are flagged.
  function automatic logic [1:0] status_code(input stage_t s);
    if (s.exception) return STATUS_EXC;
    if (s.eof) return STATUS_EOF;
    return STATUS_OK;
  endfunction

endpackage

// File: rtl/fp_writeback_if.sv
// Handshake, result and register-read bundle between the FP add/sub stage and fp_writeback.
interface fp_writeback_if #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) ();
  localparam int AW = $clog2(NUM_REGS);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_result;
  logic              i_exception;
  logic [AW-1:0]     i_rd;
  logic              i_eof;
  logic [AW-1:0]     i_rs1_addr;
  logic [AW-1:0]     i_rs2_addr;
  logic [DATA_W-1:0] o_rs1_data;
  logic [DATA_W-1:0] o_rs2_data;
  logic              o_status_valid;
  logic [1:0]        o_status;
  logic              o_halt;
  logic [15:0]       o_retired;

  modport master (
    output i_valid, i_result, i_exception, i_rd, i_eof, i_rs1_addr, i_rs2_addr,
    input  o_ready, o_rs1_data, o_rs2_data, o_status_valid, o_status, o_halt, o_retired
  );

  modport slave (
    input  i_valid, i_result, i_exception, i_rd, i_eof, i_rs1_addr, i_rs2_addr,
    output o_ready, o_rs1_data, o_rs2_data, o_status_valid, o_status, o_halt, o_retired
  );
endinterface

// File: rtl/fp_regfile.sv
// FP register file: one write port, two combinational read ports, synchronous clear.
// Macro FP_WB_BYPASS_EN forwards the in-flight write data to matching reads.
module fp_regfile #(
  parameter  int NUM_REGS = 32,
  parameter  int DATA_W   = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_rs1_addr,
  input  logic [AW-1:0]     i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data
);
  localparam logic [AW:0] NUM_REGS_W = (AW + 1)'(NUM_REGS);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [AW-1:0]     w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr[0] = i_rs1_addr;
  assign w_raddr[1] = i_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] w_mem_data;
    assign w_mem_data = ({1'b0, w_raddr[gi]} < NUM_REGS_W) ? r_mem[w_raddr[gi]] : '0;
`ifdef FP_WB_BYPASS_EN
    assign w_rdata[gi] = (i_we && (i_waddr == w_raddr[gi])) ? i_wdata : w_mem_data;
`else
    assign w_rdata[gi] = w_mem_data;
`endif
  end

  assign o_rs1_data = w_rdata[0];
  assign o_rs2_data = w_rdata[1];

endmodule

// File: rtl/fp_writeback.sv
// fp_writeback: single-entry writeback stage with halt-on-exception / halt-on-EOF FSM.
// Optional macro FP_WB_BYPASS_EN enables write-to-read forwarding in fp_regfile.
module fp_writeback
  import fp_writeback_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  fp_writeback_if.slave bus
);
  localparam int          RD_W       = $clog2(NUM_REGS);
  localparam logic [RD_W:0] NUM_REGS_W = (RD_W + 1)'(NUM_REGS);

  state_e      r_state;
  stage_t      r_stage;
  logic        r_stage_valid;
  logic        r_status_valid;
  logic [1:0]  r_status;
  logic        r_halt;
  logic [15:0] r_retired;

  stage_t          w_in;
  logic            w_transfer;
  logic            w_retire;
  logic            w_we;
  logic [RD_W-1:0] w_stage_rd;

  always_comb begin
    w_in           = '0;
    w_in.result    = FP_DATA_W'(bus.i_result);
    w_in.exception = bus.i_exception;
    w_in.rd        = FP_RD_W'(bus.i_rd);
    w_in.eof       = bus.i_eof;
  end

  assign w_transfer = bus.i_valid && (r_state == ST_RUN);
  assign w_stage_rd = RD_W'(r_stage.rd);
  assign w_retire   = r_stage_valid && !r_stage.exception;
  // Out-of-range destinations still retire; only the array write is dropped.
  assign w_we       = w_retire && ({1'b0, w_stage_rd} < NUM_REGS_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_RUN;
      r_stage        <= '0;
      r_stage_valid  <= 1'b0;
      r_status_valid <= 1'b0;
      r_status       <= STATUS_OK;
      r_halt         <= 1'b0;
      r_retired      <= '0;
    end else begin
      r_stage_valid  <= w_transfer;
      r_status_valid <= w_transfer;
      if (w_transfer) begin
        r_stage  <= w_in;
        r_status <= status_code(w_in);
      end
      case (r_state)
        ST_RUN: begin
          if (w_transfer && w_in.exception) begin
            r_state <= ST_HALT_EXC;
            r_halt  <= 1'b1;
          end else if (w_transfer && w_in.eof) begin
            r_state <= ST_HALT_EOF;
            r_halt  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_retire && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
    end
  end

  fp_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (w_we),
    .i_waddr    (w_stage_rd),
    .i_wdata    (DATA_W'(r_stage.result)),
    .i_rs1_addr (bus.i_rs1_addr),
    .i_rs2_addr (bus.i_rs2_addr),
    .o_rs1_data (bus.o_rs1_data),
    .o_rs2_data (bus.o_rs2_data)
  );

  // A reset landing while an entry is pending cancels its report along with its write.
  assign bus.o_status_valid = r_status_valid && !i_rst;
  assign bus.o_status       = r_status;
  assign bus.o_halt         = r_halt;
  assign bus.o_retired      = r_retired;
  assign bus.o_ready        = (r_state == ST_RUN);

endmodule

// File: tb/tb_fp_writeback.sv
// Scoreboard bench for fp_writeback: directed transfers push expected status codes,
// a negedge monitor pops and compares every status pulse.
module tb_fp_writeback;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_EXC = 2'b10;
  localparam logic [1:0] ST_EOF = 2'b11;
`ifdef FP_WB_BYPASS_EN
  localparam logic [31:0] EXP_N1_REG5 = 32'h3F800000;
`else
  localparam logic [31:0] EXP_N1_REG5 = 32'h00000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   quiet   = 1'b0;
  logic [1:0] exp_q [$];
  logic [1:0] mon_exp;

  always #5 clk = ~clk;

  fp_writeback_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) bus ();

  fp_writeback #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    bus.i_rs1_addr = addr;
    bus.i_rs2_addr = addr;
    #1;
    check({name, "_rs1"}, bus.o_rs1_data, exp);
    check({name, "_rs2"}, bus.o_rs2_data, exp);
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [31:0] data, input logic exc, input logic [4:0] rd,
                      input logic eof, input bit accept, input logic [1:0] st);
    bus.i_valid     = 1'b1;
    bus.i_result    = data;
    bus.i_exception = exc;
    bus.i_rd        = rd;
    bus.i_eof       = eof;
    if (accept) exp_q.push_back(st);
    $display("[TB] send data=%h exc=%b eof=%b rd=%0d accept_expected=%0d", data, exc, eof, rd, accept);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.o_status_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL status_unexpected: got pulse with status %b, expected no pulse", bus.o_status);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.o_status !== mon_exp) begin
          n_fail++;
          $display("FAIL status_code: got %b, expected %b", bus.o_status, mon_exp);
        end else if (!quiet) begin
          $display("[TB] status pulse %b", bus.o_status);
        end
      end
    end
  end

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_result    = '0;
    bus.i_exception = 1'b0;
    bus.i_rd        = '0;
    bus.i_eof       = 1'b0;
    bus.i_rs1_addr  = '0;
    bus.i_rs2_addr  = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(bus.o_ready), 32'd1);
    check("reset_halt", 32'(bus.o_halt), 32'd0);
    check("reset_retired", 32'(bus.o_retired), 32'd0);
    check("reset_status_valid", 32'(bus.o_status_valid), 32'd0);
    check("reset_status", 32'(bus.o_status), 32'd0);
    rd_check("reset_reg5", 5'd5, 32'h0);

    // Basic write and read-back latency
    send(32'h3F800000, 1'b0, 5'd5, 1'b0, 1'b1, ST_OK);
    @(negedge clk);
    rd_check("reg5_n1", 5'd5, EXP_N1_REG5);
    wait_cycles(1);
    rd_check("reg5_n2", 5'd5, 32'h3F800000);
    check("retired_after_one", 32'(bus.o_retired), 32'd1);

    // Back-to-back transfers to the same register
    do_reset();
    send(32'h3F800000, 1'b0, 5'd2, 1'b0, 1'b1, ST_OK);
    send(32'hBF800000, 1'b0, 5'd2, 1'b0, 1'b1, ST_OK);
    wait_cycles(2);
    rd_check("reg2_b2b", 5'd2, 32'hBF800000);
    check("retired_b2b", 32'(bus.o_retired), 32'd2);

    // Exception halts and suppresses the write; later valids ignored
    do_reset();
    send(32'h7F800000, 1'b1, 5'd3, 1'b0, 1'b1, ST_EXC);
    @(negedge clk);
    check("exc_halt_n1", 32'(bus.o_halt), 32'd1);
    check("exc_ready_n1", 32'(bus.o_ready), 32'd0);
    send(32'h12345678, 1'b0, 5'd4, 1'b0, 1'b0, ST_OK);
    wait_cycles(2);
    rd_check("exc_reg3", 5'd3, 32'h0);
    rd_check("exc_reg4_ignored", 5'd4, 32'h0);
    check("exc_retired", 32'(bus.o_retired), 32'd0);
    check("exc_halt_held", 32'(bus.o_halt), 32'd1);

    // EOF writes its result then halts
    do_reset();
    send(32'h40000000, 1'b0, 5'd7, 1'b1, 1'b1, ST_EOF);
    wait_cycles(1);
    rd_check("eof_reg7", 5'd7, 32'h40000000);
    check("eof_retired", 32'(bus.o_retired), 32'd1);
    check("eof_halt", 32'(bus.o_halt), 32'd1);
    check("eof_ready", 32'(bus.o_ready), 32'd0);
    send(32'h11111111, 1'b0, 5'd6, 1'b0, 1'b0, ST_OK);
    wait_cycles(2);
    rd_check("eof_reg6_ignored", 5'd6, 32'h0);
    check("eof_retired_held", 32'(bus.o_retired), 32'd1);

    // Exception outranks EOF
    do_reset();
    send(32'h3F800000, 1'b1, 5'd8, 1'b1, 1'b1, ST_EXC);
    wait_cycles(1);
    rd_check("prio_reg8", 5'd8, 32'h0);
    check("prio_retired", 32'(bus.o_retired), 32'd0);
    check("prio_halt", 32'(bus.o_halt), 32'd1);

    // Reset in the cycle after a transfer discards the pending entry
    do_reset();
    bus.i_valid = 1'b1; bus.i_result = 32'h3F800000; bus.i_exception = 1'b0;
    bus.i_rd = 5'd9; bus.i_eof = 1'b0;
    $display("[TB] send data=3f800000 rd=9 followed by reset");
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(1);
    rd_check("rst_after_reg9", 5'd9, 32'h0);
    check("rst_after_retired", 32'(bus.o_retired), 32'd0);
    check("rst_after_ready", 32'(bus.o_ready), 32'd1);

    // Reset simultaneous with a transfer
    rst = 1'b1;
    bus.i_valid = 1'b1; bus.i_result = 32'h40400000; bus.i_rd = 5'd10;
    $display("[TB] send data=40400000 rd=10 during reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    wait_cycles(2);
    rd_check("rst_sim_reg10", 5'd10, 32'h0);
    check("rst_sim_retired", 32'(bus.o_retired), 32'd0);

    // Saturate the retired counter
    do_reset();
    quiet = 1'b1;
    $display("[TB] burst of 65535 transfers to rd=1");
    bus.i_valid = 1'b1; bus.i_result = 32'h3F800000; bus.i_exception = 1'b0;
    bus.i_rd = 5'd1; bus.i_eof = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      exp_q.push_back(ST_OK);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    wait_cycles(2);
    quiet = 1'b0;
    check("sat_retired_full", 32'(bus.o_retired), 32'h0000FFFF);
    send(32'h40400000, 1'b0, 5'd1, 1'b0, 1'b1, ST_OK);
    wait_cycles(1);
    check("sat_retired_held", 32'(bus.o_retired), 32'h0000FFFF);
    rd_check("sat_reg1", 5'd1, 32'h40400000);

    wait_cycles(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_writeback.md
FP_WRITEBACK -- requirements
Module: fp_writeback

Interface
REQ-001 Parameter NUM_REGS, default 32, number of FP registers.
REQ-002 Parameter DATA_W, default 32, register and result width in bits (IEEE-754 single).
REQ-003 i_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  result from the FP add/sub stage is present.
REQ-006 o_ready  output  1  block accepts a result this cycle.
REQ-007 i_result  input  DATA_W  FP result word {sign, exp, man}.
REQ-008 i_exception  input  1  result is invalid (INF/NaN input or overflow).
REQ-009 i_rd  input  $clog2(NUM_REGS)  destination register index.
REQ-010 i_eof  input  1  end-of-program marker, sampled with the same handshake.
REQ-011 i_rs1_addr, i_rs2_addr  input  $clog2(NUM_REGS)  operand read addresses.
REQ-012 o_rs1_data, o_rs2_data  output  DATA_W  combinational operand read data.
REQ-013 o_status_valid  output  1  one-cycle status pulse.
REQ-014 o_status  output  2  status code: 00 OK, 10 EXCEPTION, 11 EOF.
REQ-015 o_halt  output  1  block has stopped accepting results.
REQ-016 o_retired  output  16  count of results written.

Function
REQ-017 Transfer SHALL occur in cycle n iff i_valid && o_ready; i_* fields are captured into a single-entry stage register.
REQ-018 o_ready SHALL be 1 only in state RUN; the stage register drains every cycle, so no other backpressure exists.
REQ-019 States: RUN, HALT_EXC, HALT_EOF; RUN->HALT_EXC on a transfer with i_exception=1; RUN->HALT_EOF on a transfer with i_eof=1 and i_exception=0; both halt states are left only by reset.
REQ-020 A transfer with i_exception=0 SHALL write i_result to register i_rd at the end of cycle n+1 and increment o_retired, saturating at 16'hFFFF.
REQ-021 A transfer with i_exception=1 SHALL NOT write any register and SHALL NOT increment o_retired.
REQ-022 A transfer with i_eof=1 and i_exception=0 SHALL still write its result before entering HALT_EOF; i_exception takes priority over i_eof.
REQ-023 o_status_valid SHALL pulse for exactly one cycle in cycle n+1 after every transfer, with o_status 10 if exception, else 11 if eof, else 00.
REQ-024 o_halt SHALL be 1 from cycle n+1 after the halting transfer until reset.
REQ-025 Reads SHALL return register contents combinationally; all registers, including index 0, are writable.
REQ-026 Out-of-range i_rd (>= NUM_REGS) SHALL suppress the write but still count and report as OK.

Reset
REQ-027 On i_rst=1 at a rising edge: state RUN, stage register empty, all registers 0, o_retired 0, o_status_valid 0, o_status 00, o_halt 0; o_ready is 1 in the following cycle.
REQ-028 Reset SHALL take priority over a simultaneous transfer; a pending stage entry SHALL be discarded without writing.

Configuration
REQ-029 Macro FP_WB_BYPASS_EN: when defined, a read whose address matches the valid, non-exception stage entry SHALL return that entry's data in cycle n+1 (write-to-read forwarding); when undefined, new data is visible from cycle n+2 only.

Structure
REQ-030 A shared package SHALL hold the state enum, the 2-bit status code constants, and the stage-entry struct {result, exception, rd, eof}.
REQ-031 The register array with its two read ports and optional bypass SHALL be a sub-module named fp_regfile.

Verification
REQ-032 Reset, then transfer result 32'h3F800000 to rd=5 -> cycle n+1 status 00 pulse; o_rs1_data at addr 5 equals 32'h3F800000 in n+2 (n+1 with bypass); o_retired=1.
REQ-033 Transfer 32'h7F800000 with i_exception=1, rd=3 -> register 3 stays 0, status 10, o_halt=1, o_ready=0; subsequent i_valid ignored.
REQ-034 Transfer 32'h40000000, rd=7, i_eof=1 -> register 7 = 32'h40000000, status 11, o_retired incremented, HALT_EOF.
REQ-035 Back-to-back transfers to rd=2 with 32'h3F800000 then 32'hBF800000 on consecutive cycles -> final register 2 = 32'hBF800000, o_retired=2, two OK pulses.
REQ-036 Assert i_rst in the cycle after a transfer to rd=9 -> register 9 remains 0, no status pulse, o_retired=0.
REQ-037 Preload o_retired to 16'hFFFF via repeated transfers -> one further transfer leaves o_retired at 16'hFFFF.
